i2s_clk_arbiter: RTL and testbench
==================================

// Module: i2s_clk_arbiter
// PURPOSE
//  Shares one i2s_clk_gen SCK divider between NUM_REQ requesters (RX/TX channels).
//  Round-robin grants ownership and loads the owner's semiperiod.
//  Sequences the divider enable/ack handshake so SCK always starts and stops cleanly low.
//  Sits between the channel config regs and the divider's cfg_clk_en_i/cfg_semiperiod_cycles_i.
// PARAMETERS
//  NUM_REQ  2  number of requesters, >=2
// PORTS
//  clk_i          in   1            system clock
//  rstn_i         in   1            reset, asynchronous, active-low
//  req_i          in   NUM_REQ      level request for SCK, held while SCK needed
//  semiperiod_i   in   NUM_REQ*16   per-requester semiperiod, req k at [16k+15:16k]
//  gnt_o          out  NUM_REQ      one-hot owner, zero when no owner
//  running_o      out  1            owner's SCK is running (state RUN)
//  clk_en_o       out  1            to divider cfg_clk_en_i
//  semiperiod_o   out  16           to divider cfg_semiperiod_cycles_i
//  clk_en_ack_i   in   1            from divider cfg_clk_en_o
// BEHAVIOUR
//  Reset: state IDLE, gnt_o=0, running_o=0, clk_en_o=0, semiperiod_o=0, rr pointer=0.
//  All outputs registered or decoded from registered state only; no comb req->out path.
//  FSM states IDLE, START, RUN, STOP:
//  - IDLE: clk_en_o=0. If |req_i and clk_en_ack_i==0: pick winner round-robin,
//    search from ptr upward with wrap; gnt_o<=onehot(winner),
//    semiperiod_o<=semiperiod_i[winner], ptr<=winner+1 (mod NUM_REQ), ->START.
//    If clk_en_ack_i==1, no grant.
//  - START: clk_en_o=1. If req_i[owner]==0 ->STOP. Else if clk_en_ack_i==1 ->RUN.
//  - RUN: clk_en_o=1, running_o=1. req_i[owner]==0 ->STOP. Other reqs wait; no preemption.
//  - STOP: clk_en_o=0, gnt_o held. When clk_en_ack_i==0 (divider parked SCK low):
//    gnt_o<=0 ->IDLE.
//  Latency:
//  - req rises at edge 0 (IDLE): gnt_o/clk_en_o/semiperiod_o high after edge 0.
//  - With the divider, ack high after edge 1; running_o high after edge 2.
//  Config rules:
//  - semiperiod_o is latched only at grant.
//  - semiperiod_i changes by the owner are ignored until it re-requests.
//  - The divider needs 1 cycle; semiperiod_o is stable while clk_en_o high, width 16 unsigned.
//  Boundaries:
//  - Owner re-asserts req in STOP: STOP still completes; owner re-arbitrates in IDLE
//    at the next ptr position.
//  - Simultaneous reqs: lowest index at/after ptr wins.
//  - Minimum one IDLE cycle (gnt_o=0) between owners.
//  - req drop same cycle as ack rise in START: ->STOP, not RUN.
//  - Reset mid-operation: all outputs return to reset values immediately (async).
//  - Divider self-stops via its own cfg_clk_en_i=0.
// TESTING
//  1 Single req:
//    req_i=01, sp0=4 -> gnt=01, sp_o=4, clk_en=1 next cycle; running_o 2 cycles later;
//    SCK period 10 clk.
//  2 Round-robin:
//    req_i=11 held, each owner drops after 40 cycles and re-requests -> gnts 01,10,01,10
//    with >=1 idle cycle between.
//  3 Drop while SCK high:
//    owner drops req mid high phase (sp=7) -> clk_en_o=0, gnt held until ack low,
//    SCK ends low, then gnt=0.
//  4 Drop in START:
//    req pulses 1 cycle -> START->STOP->IDLE, no SCK edge, gnt returns 0 once ack=0.
//  5 Stale ack:
//    force clk_en_ack_i=1 in IDLE with req=01 -> no grant until ack=0, then grant next edge.
//  6 Reset in RUN:
//    rstn_i low for 1 cycle -> gnt_o=0, clk_en_o=0, running_o=0 immediately;
//    re-arbitration from ptr=0 after release.

Source files
------------

// File: rtl/i2s_clk_arbiter.sv
// Round-robin owner of a shared i2s_clk_gen SCK divider.
// Sequences the divider enable/ack handshake so SCK always starts and stops low.
module i2s_clk_arbiter #(
   parameter int NUM_REQ = 2
) (
   input  logic                  clk_i,
   input  logic                  rstn_i,
   input  logic [NUM_REQ-1:0]    req_i,
   input  logic [NUM_REQ*16-1:0] semiperiod_i,
   output logic [NUM_REQ-1:0]    gnt_o,
   output logic                  running_o,
   output logic                  clk_en_o,
   output logic [15:0]           semiperiod_o,
   input  logic                  clk_en_ack_i
);

   localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   typedef enum logic [1:0] {IDLE, START, RUN, STOP} state_t;

   state_t             state, state_nxt;
   logic [PTR_W-1:0]   ptr, ptr_nxt;
   logic [NUM_REQ-1:0] gnt, gnt_nxt;
   logic [15:0]        sp, sp_nxt;

   logic               found_hi, found_lo;
   logic [PTR_W-1:0]   win_hi, win_lo, winner;
   logic               owner_req;

   // Lowest requester at/after ptr wins, otherwise wrap to the lowest overall.
   always_comb begin
      found_hi = 1'b0;
      found_lo = 1'b0;
      win_hi   = '0;
      win_lo   = '0;
      for (int j = NUM_REQ - 1; j >= 0; j--) begin
         if (req_i[j]) begin
            found_lo = 1'b1;
            win_lo   = PTR_W'(j);
            if (j >= int'(ptr)) begin
               found_hi = 1'b1;
               win_hi   = PTR_W'(j);
            end
         end
      end
      winner = found_hi ? win_hi : win_lo;
   end

   assign owner_req = |(req_i & gnt);

   always_comb begin
      state_nxt = state;
      ptr_nxt   = ptr;
      gnt_nxt   = gnt;
      sp_nxt    = sp;
      unique case (state)
         IDLE: begin
            if (found_lo && !clk_en_ack_i) begin
               gnt_nxt   = {{(NUM_REQ-1){1'b0}}, 1'b1} << winner;
               sp_nxt    = semiperiod_i[winner*16 +: 16];
               ptr_nxt   = (int'(winner) == NUM_REQ - 1) ? '0 : winner + 1'b1;
               state_nxt = START;
            end
         end
         START: begin
            if (!owner_req) begin
               state_nxt = STOP;
            end else if (clk_en_ack_i) begin
               state_nxt = RUN;
            end
         end
         RUN: begin
            if (!owner_req) begin
               state_nxt = STOP;
            end
         end
         STOP: begin
            // Ownership is only released once the divider has parked SCK low.
            if (!clk_en_ack_i) begin
               gnt_nxt   = '0;
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         state <= IDLE;
         ptr   <= '0;
         gnt   <= '0;
         sp    <= '0;
      end else begin
         state <= state_nxt;
         ptr   <= ptr_nxt;
         gnt   <= gnt_nxt;
         sp    <= sp_nxt;
      end
   end

   assign gnt_o        = gnt;
   assign semiperiod_o = sp;
   assign clk_en_o     = (state == START) || (state == RUN);
   assign running_o    = (state == RUN);

endmodule

// File: tb/tb_i2s_clk_arbiter.sv
// Bench for i2s_clk_arbiter: a divider model drives the ack, a transaction-level
// ownership model predicts the arbiter outputs every cycle, plus directed literal checks.
module tb_i2s_clk_arbiter;
   localparam int N = 2;

   logic          clk_i = 1'b0;
   logic          rstn_i = 1'b1;
   logic [N-1:0]  req_i = '0;
   logic [N*16-1:0] semiperiod_i = '0;
   logic [N-1:0]  gnt_o;
   logic          running_o, clk_en_o, clk_en_ack_i;
   logic [15:0]   semiperiod_o;

   int n_cmp = 0;
   int n_err = 0;

   i2s_clk_arbiter #(.NUM_REQ(N)) dut (
      .clk_i(clk_i), .rstn_i(rstn_i), .req_i(req_i), .semiperiod_i(semiperiod_i),
      .gnt_o(gnt_o), .running_o(running_o), .clk_en_o(clk_en_o),
      .semiperiod_o(semiperiod_o), .clk_en_ack_i(clk_en_ack_i)
   );

   always #5 clk_i = ~clk_i;

   // Divider stand-in: acks one cycle after enable, finishes a high phase before parking.
   logic        div_ack, sck, force_ack = 1'b0;
   logic [15:0] cnt;
   assign clk_en_ack_i = div_ack | force_ack;

   always @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         div_ack <= 1'b0; sck <= 1'b0; cnt <= '0;
      end else if (!div_ack) begin
         if (clk_en_o) begin div_ack <= 1'b1; sck <= 1'b0; cnt <= '0; end
      end else if (clk_en_o || sck) begin
         if (cnt == semiperiod_o) begin sck <= ~sck; cnt <= '0; end
         else cnt <= cnt + 16'd1;
      end else begin
         div_ack <= 1'b0;
      end
   end

   // Ownership model: who owns the divider, whether enable is asked, whether ack confirmed.
   bit          m_busy = 0, m_en = 0, m_run = 0, m_found;
   int          m_owner = 0, m_ptr = 0, m_c;
   logic [15:0] m_sp = '0;

   always @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         m_busy = 0; m_en = 0; m_run = 0; m_owner = 0; m_ptr = 0; m_sp = '0;
      end else if (!m_busy) begin
         if (req_i != 0 && !clk_en_ack_i) begin
            m_found = 0;
            for (int k = 0; k < N; k++) begin
               m_c = (m_ptr + k) % N;
               if (!m_found && req_i[m_c]) begin m_found = 1; m_owner = m_c; end
            end
            m_busy = 1; m_en = 1; m_run = 0;
            m_sp   = semiperiod_i[m_owner*16 +: 16];
            m_ptr  = (m_owner + 1) % N;
         end
      end else if (m_en) begin
         if (!req_i[m_owner]) begin m_en = 0; m_run = 0; end
         else if (clk_en_ack_i) m_run = 1;
      end else if (!clk_en_ack_i) begin
         m_busy = 0;
      end
   end

   logic [N-1:0] exp_gnt;
   always @(negedge clk_i) begin
      exp_gnt = m_busy ? N'(1 << m_owner) : '0;
      n_cmp++;
      if (gnt_o !== exp_gnt || clk_en_o !== m_en || running_o !== m_run || semiperiod_o !== m_sp) begin
         n_err++;
         $display("[TB] FAIL model @%0t gnt=%b exp %b clk_en=%b exp %b running=%b exp %b sp=%0d exp %0d",
                  $time, gnt_o, exp_gnt, clk_en_o, m_en, running_o, m_run, semiperiod_o, m_sp);
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk_i);
      #1;
   endtask

   task automatic applyStimulus(input logic [N-1:0] req, input logic [15:0] sp0, input logic [15:0] sp1);
      req_i        = req;
      semiperiod_i = {sp1, sp0};
   endtask

   task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("[TB] FAIL %s @%0t got %0h expected %0h", name, $time, act, exp);
      end
   endtask

   task automatic waitGnt(input bit want_zero, input string name);
      for (int i = 0; i < 200 && ((gnt_o == 0) != want_zero); i++) tick(1);
      checkOutput(name, 16'((gnt_o == 0) == want_zero), 16'd1);
   endtask

   logic [N-1:0] rr_exp [4] = '{2'b01, 2'b10, 2'b01, 2'b10};

   initial begin
      #1 rstn_i = 1'b0;
      tick(2);
      checkOutput("rst_gnt", 16'(gnt_o), 16'd0);
      checkOutput("rst_clk_en", 16'(clk_en_o), 16'd0);
      checkOutput("rst_running", 16'(running_o), 16'd0);
      checkOutput("rst_sp", semiperiod_o, 16'd0);
      rstn_i = 1'b1;
      tick(1);

      $display("[TB] single request");
      applyStimulus(2'b01, 16'd4, 16'd9);
      tick(1);
      checkOutput("t1_gnt", 16'(gnt_o), 16'd1);
      checkOutput("t1_clk_en", 16'(clk_en_o), 16'd1);
      checkOutput("t1_sp", semiperiod_o, 16'd4);
      checkOutput("t1_run_e0", 16'(running_o), 16'd0);
      tick(1);
      checkOutput("t1_run_e1", 16'(running_o), 16'd0);
      tick(1);
      checkOutput("t1_run_e2", 16'(running_o), 16'd1);
      applyStimulus(2'b01, 16'd9, 16'd9);
      tick(5);
      checkOutput("t1_sp_held", semiperiod_o, 16'd4);
      tick(20);
      applyStimulus(2'b00, 16'd9, 16'd9);
      waitGnt(1, "t1_release");

      rstn_i = 1'b0;
      tick(1);
      rstn_i = 1'b1;
      tick(1);

      $display("[TB] round robin");
      applyStimulus(2'b11, 16'd3, 16'd5);
      for (int g = 0; g < 4; g++) begin
         waitGnt(0, "t2_grant_wait");
         checkOutput("t2_rr_gnt", 16'(gnt_o), 16'(rr_exp[g]));
         tick(40);
         applyStimulus(2'b11 & ~gnt_o, 16'd3, 16'd5);
         tick(1);
         applyStimulus((g == 3) ? 2'b00 : 2'b11, 16'd3, 16'd5);
         waitGnt(1, "t2_idle_gap");
      end

      $display("[TB] drop while SCK high");
      applyStimulus(2'b01, 16'd7, 16'd0);
      for (int i = 0; i < 50 && !(running_o && sck); i++) tick(1);
      checkOutput("t3_sck_high", 16'(running_o && sck), 16'd1);
      tick(2);
      applyStimulus(2'b00, 16'd7, 16'd0);
      tick(1);
      checkOutput("t3_clk_en_off", 16'(clk_en_o), 16'd0);
      checkOutput("t3_gnt_held", 16'(gnt_o), 16'd1);
      tick(2);
      checkOutput("t3_gnt_held2", 16'(gnt_o), 16'd1);
      waitGnt(1, "t3_release");
      checkOutput("t3_sck_low", 16'(sck), 16'd0);

      $display("[TB] drop in START as ack rises");
      applyStimulus(2'b01, 16'd4, 16'd0);
      tick(1);
      checkOutput("t4_gnt", 16'(gnt_o), 16'd1);
      tick(1);
      checkOutput("t4_start_run", 16'(running_o), 16'd0);
      applyStimulus(2'b00, 16'd4, 16'd0);
      tick(1);
      checkOutput("t4_no_run", 16'(running_o), 16'd0);
      checkOutput("t4_clk_en_off", 16'(clk_en_o), 16'd0);
      checkOutput("t4_gnt_held", 16'(gnt_o), 16'd1);
      waitGnt(1, "t4_release");

      $display("[TB] stale ack");
      tick(2);
      force_ack = 1'b1;
      applyStimulus(2'b01, 16'd6, 16'd0);
      tick(3);
      checkOutput("t5_no_grant", 16'(gnt_o), 16'd0);
      force_ack = 1'b0;
      tick(1);
      checkOutput("t5_grant", 16'(gnt_o), 16'd1);
      checkOutput("t5_sp", semiperiod_o, 16'd6);

      $display("[TB] reset in RUN");
      tick(5);
      checkOutput("t6_running", 16'(running_o), 16'd1);
      rstn_i = 1'b0;
      applyStimulus(2'b11, 16'd2, 16'd3);
      #1;
      checkOutput("t6_gnt_async", 16'(gnt_o), 16'd0);
      checkOutput("t6_clk_en_async", 16'(clk_en_o), 16'd0);
      checkOutput("t6_running_async", 16'(running_o), 16'd0);
      checkOutput("t6_sp_async", semiperiod_o, 16'd0);
      tick(1);
      rstn_i = 1'b1;
      tick(1);
      checkOutput("t6_ptr0_gnt", 16'(gnt_o), 16'd1);
      checkOutput("t6_ptr0_sp", semiperiod_o, 16'd2);
      applyStimulus(2'b00, 16'd2, 16'd3);
      waitGnt(1, "t6_release");
      tick(2);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
